// File: rtl/level_status_monitor_if.sv
// Signal bundle between the level rule checker and its surroundings:
// per-frame sampling strobe, collision/door/gem flags in, sticky status
// levels and HUD gem tallies out.
interface level_status_monitor_if #(
    parameter int GEM_W = 4
);
    logic             frame_tick;
    logic             revive;
    logic             fire_hazard;
    logic             ice_hazard;
    logic             fire_at_door;
    logic             ice_at_door;
    logic             fire_gem;
    logic             ice_gem;
    logic             gameover;
    logic             gamewin;
    logic             playing;
    logic [GEM_W-1:0] fire_gems;
    logic [GEM_W-1:0] ice_gems;

    // Game world / controller side: drives the flags, reads the status.
    modport master (
        output frame_tick, revive, fire_hazard, ice_hazard,
               fire_at_door, ice_at_door, fire_gem, ice_gem,
        input  gameover, gamewin, playing, fire_gems, ice_gems
    );

    // Rule checker side.
    modport slave (
        input  frame_tick, revive, fire_hazard, ice_hazard,
               fire_at_door, ice_at_door, fire_gem, ice_gem,
        output gameover, gamewin, playing, fire_gems, ice_gems
    );
endinterface

// File: rtl/level_status_monitor.sv
// Per-level rule checker. Debounces hazard contact and door occupancy over
// consecutive video frames, declares a sticky loss or win, and tallies
// collected gems for the HUD. A revive pulse re-arms it for a fresh level.
module level_status_monitor #(
    parameter int DEATH_FRAMES = 3,
    parameter int WIN_FRAMES   = 30,
    parameter int GEM_W        = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    level_status_monitor_if.slave  bus
);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_LOST = 2'd2;
    localparam logic [1:0] ST_WON  = 2'd3;

    localparam logic [3:0]       DEATH_TH = 4'(DEATH_FRAMES);
    localparam logic [5:0]       WIN_TH   = 6'(WIN_FRAMES);
    localparam logic [GEM_W-1:0] GEM_MAX  = {GEM_W{1'b1}};
    localparam logic [GEM_W-1:0] GEM_ONE  = {{(GEM_W-1){1'b0}}, 1'b1};

    // Saturating increment: a full counter stays full instead of wrapping.
    function automatic logic [GEM_W-1:0] sat_inc(input logic [GEM_W-1:0] val,
                                                 input logic             en);
        logic [GEM_W-1:0] res;
        if (en && (val != GEM_MAX)) begin
            res = val + GEM_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [3:0]       hcnt_r;
    logic [5:0]       dcnt_r;
    logic [GEM_W-1:0] fire_gems_r;
    logic [GEM_W-1:0] ice_gems_r;
    logic             gameover_r;
    logic             gamewin_r;
    logic             playing_r;

    logic [1:0]       state_nxt_s;
    logic [3:0]       hcnt_nxt_s;
    logic [5:0]       dcnt_nxt_s;
    logic [GEM_W-1:0] fire_gems_nxt_s;
    logic [GEM_W-1:0] ice_gems_nxt_s;
    logic [3:0]       hinc_s;
    logic [5:0]       dinc_s;
    logic             hit_s;
    logic             door_s;

    assign hinc_s = hcnt_r + 4'd1;
    assign dinc_s = dcnt_r + 6'd1;
    assign hit_s  = bus.fire_hazard | bus.ice_hazard;
    assign door_s = bus.fire_at_door & bus.ice_at_door;

    // Next-state and counter update: revive overrides everything, otherwise
    // only PLAY reacts to inputs; death is checked before win.
    always_comb begin
        state_nxt_s     = state_r;
        hcnt_nxt_s      = hcnt_r;
        dcnt_nxt_s      = dcnt_r;
        fire_gems_nxt_s = fire_gems_r;
        ice_gems_nxt_s  = ice_gems_r;
        if (bus.revive) begin
            state_nxt_s     = ST_PLAY;
            hcnt_nxt_s      = 4'd0;
            dcnt_nxt_s      = 6'd0;
            fire_gems_nxt_s = {GEM_W{1'b0}};
            ice_gems_nxt_s  = {GEM_W{1'b0}};
        end else if (state_r == ST_PLAY) begin
            fire_gems_nxt_s = sat_inc(fire_gems_r, bus.fire_gem);
            ice_gems_nxt_s  = sat_inc(ice_gems_r, bus.ice_gem);
            if (bus.frame_tick) begin
                if (hit_s) begin
                    hcnt_nxt_s = hinc_s;
                end else begin
                    hcnt_nxt_s = 4'd0;
                end
                if (door_s) begin
                    dcnt_nxt_s = dinc_s;
                end else begin
                    dcnt_nxt_s = 6'd0;
                end
                if (hit_s && (hinc_s == DEATH_TH)) begin
                    state_nxt_s = ST_LOST;
                end else if (door_s && (dinc_s == WIN_TH)) begin
                    state_nxt_s = ST_WON;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end else begin
                hcnt_nxt_s = hcnt_r;
                dcnt_nxt_s = dcnt_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered status outputs; status flags are
    // decoded from the next state so they line up with the state register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= ST_WAIT;
            hcnt_r      <= 4'd0;
            dcnt_r      <= 6'd0;
            fire_gems_r <= {GEM_W{1'b0}};
            ice_gems_r  <= {GEM_W{1'b0}};
            gameover_r  <= 1'b0;
            gamewin_r   <= 1'b0;
            playing_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hcnt_r      <= hcnt_nxt_s;
            dcnt_r      <= dcnt_nxt_s;
            fire_gems_r <= fire_gems_nxt_s;
            ice_gems_r  <= ice_gems_nxt_s;
            case (state_nxt_s)
                ST_PLAY: begin
                    gameover_r <= 1'b0;
                    gamewin_r  <= 1'b0;
                    playing_r  <= 1'b1;
                end
                ST_LOST: begin
                    gameover_r <= 1'b1;
                    gamewin_r  <= 1'b0;
                    playing_r  <= 1'b0;
                end
                ST_WON: begin
                    gameover_r <= 1'b0;
                    gamewin_r  <= 1'b1;
                    playing_r  <= 1'b0;
                end
                default: begin
                    gameover_r <= 1'b0;
                    gamewin_r  <= 1'b0;
                    playing_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gameover  = gameover_r;
    assign bus.gamewin   = gamewin_r;
    assign bus.playing   = playing_r;
    assign bus.fire_gems = fire_gems_r;
    assign bus.ice_gems  = ice_gems_r;

endmodule
